// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: button sync, step pacing and score/level/lives sequencing for the LED guessing game
module guess_game_ctrl #(
    parameter int CNT_W     = 27,
    parameter int BASE_DIV  = 50000000,
    parameter int DIV_STEP  = 5000000,
    parameter int MAX_LEVEL = 7,
    parameter int LIVES     = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_btn_in,
    input  logic       i_fsm_win,
    input  logic       i_fsm_lose,
    output logic [3:0] o_btn_out,
    output logic       o_fsm_en,
    output logic       o_fsm_rst,
    output logic [7:0] o_score,
    output logic [2:0] o_level,
    output logic [1:0] o_lives,
    output logic       o_playing,
    output logic       o_game_over
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_WIN_HOLD, S_LOSE_HOLD, S_OVER} state_t;

    if (BASE_DIV - MAX_LEVEL * DIV_STEP < 2) begin : g_bad_period
        $error("guess_game_ctrl: shortest step period must be at least 2 cycles");
    end

    logic [3:0]       r_btn_s1, r_btn_s2;
    logic             r_start_s1, r_start_s2, r_start_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_score;
    logic [2:0]       r_level;
    logic [1:0]       r_lives;
    logic             r_fsm_rst, r_playing, r_game_over;
    logic             w_start_rise, w_wrap;
    logic [CNT_W-1:0] w_period;

    assign w_start_rise = r_start_s2 & ~r_start_prev;
    assign w_period     = CNT_W'(BASE_DIV) - CNT_W'(r_level) * CNT_W'(DIV_STEP);
    assign w_wrap       = (r_cnt == w_period - CNT_W'(1));
    assign o_btn_out    = r_btn_s2;
    assign o_fsm_en     = (r_state == S_RUN) && w_wrap;
    assign o_fsm_rst    = r_fsm_rst;
    assign o_score      = r_score;
    assign o_level      = r_level;
    assign o_lives      = r_lives;
    assign o_playing    = r_playing;
    assign o_game_over  = r_game_over;

    // two-flop synchronisers for the raw buttons plus a history flop for start edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_btn_s1     <= '0;
            r_btn_s2     <= '0;
            r_start_s1   <= 1'b0;
            r_start_s2   <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_btn_s1     <= i_btn_in;
            r_btn_s2     <= r_btn_s1;
            r_start_s1   <= i_start;
            r_start_s2   <= r_start_s1;
            r_start_prev <= r_start_s2;
        end
    end

    // step-period counter: free-runs only in RUN, idles at zero so every RUN entry starts a full period
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_cnt <= '0;
        else        r_cnt <= (r_state == S_RUN && !w_wrap) ? r_cnt + CNT_W'(1) : '0;
    end

    // game sequencer with registered status outputs updated alongside the state
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_score     <= '0;
            r_level     <= '0;
            r_lives     <= 2'(LIVES);
            r_fsm_rst   <= 1'b1;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start_rise) begin
                    r_state   <= S_ARM;
                    r_score   <= '0;
                    r_level   <= '0;
                    r_lives   <= 2'(LIVES);
                    r_playing <= 1'b1;
                end
                S_ARM: begin
                    r_state   <= S_RUN;
                    r_fsm_rst <= 1'b0;
                end
                S_RUN: if (i_fsm_win) begin
                    r_state <= S_WIN_HOLD;
                    r_score <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                    r_level <= (r_level == 3'(MAX_LEVEL)) ? r_level : r_level + 3'd1;
                end else if (i_fsm_lose) begin
                    r_state <= S_LOSE_HOLD;
                    r_lives <= r_lives - 2'd1;
                end
                S_WIN_HOLD: if (r_btn_s2 == 4'd0) begin
                    r_state   <= S_ARM;
                    r_fsm_rst <= 1'b1;
                end
                S_LOSE_HOLD: if (r_lives == 2'd0) begin
                    r_state     <= S_OVER;
                    r_fsm_rst   <= 1'b1;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b1;
                end else if (r_btn_s2 == 4'd0) begin
                    r_state   <= S_ARM;
                    r_fsm_rst <= 1'b1;
                end
                S_OVER: if (w_start_rise) begin
                    r_state     <= S_IDLE;
                    r_game_over <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_fsm_rst   <= 1'b1;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Sequencer for the LED guessing-game FSM.
- Synchronises the raw push-buttons, drives the game FSM's step enable (`fsm_en`) and its reset (`fsm_rst`), and observes its `win`/`lose` flags.
- Keeps score, level and lives. Each level shortens the step period, so the LED sweep speeds up after every win.
- Sits between the board I/O (buttons, start switch) and the guess FSM; its score, level and lives outputs feed the display logic.

Parameters:
- CNT_W, 27, width of the step-period counter.
- BASE_DIV, 50000000, clk cycles per FSM step at level 0.
- DIV_STEP, 5000000, period reduction per level.
- MAX_LEVEL, 7, highest level, saturating.
- LIVES, 3, lives at game start (1..3).
- Legality: BASE_DIV - MAX_LEVEL*DIV_STEP >= 2 (checked by assertion).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  raw start button, asynchronous to clk
- btn_in  in  4  raw guess buttons
- fsm_win  in  1  win flag from the guess FSM
- fsm_lose  in  1  lose flag from the guess FSM
- btn_out  out  4  synchronised buttons, drives the FSM `in`
- fsm_en  out  1  one-cycle step pulse to the FSM
- fsm_rst  out  1  one-cycle, active-high reset pulse to the FSM
- score  out  8  wins this game, saturates at 255
- level  out  3  current speed level
- lives  out  2  remaining lives
- playing  out  1  high in ARM, RUN, WIN_HOLD and LOSE_HOLD
- game_over  out  1  high in OVER

Behaviour:
- Reset (`rst`=0 at a clk edge):
  - state=IDLE; score=0, level=0, lives=LIVES.
  - fsm_en=0, fsm_rst=1 (held while in IDLE); btn_out=0.
  - Synchroniser, edge-detect and period-counter flops all cleared.
  - Reset asserted in any state, mid-game included, wins over all other events.
- Input synchronisation:
  - `btn_in` and `start` each pass through 2 flops; `btn_out` is the second flop. Latency is 2 cycles.
  - `start_rise` = synced start high AND the previous synced value low.
- Step period:
  - P = BASE_DIV - level*DIV_STEP, computed at CNT_W bits.
  - The counter runs only in RUN. It clears on entry to RUN and on wrap.
  - `fsm_en`=1 for exactly the cycle where cnt==P-1; the counter then returns to 0.
- States:
  - IDLE: fsm_rst=1. On start_rise, clear score and level, set lives=LIVES, go to ARM.
  - ARM: fsm_rst=1 for exactly one cycle, then go to RUN with the counter at 0.
  - RUN: emit fsm_en pulses.
    - fsm_win sampled high -> WIN_HOLD.
    - Else fsm_lose sampled high -> LOSE_HOLD.
    - If both are high, win has priority.
  - WIN_HOLD: on entry, score+1 (saturating at 255) and level+1 (saturating at MAX_LEVEL). Stay until btn_out==0, then go to ARM.
  - LOSE_HOLD: on entry, lives-1.
    - If the new lives value is 0, go to OVER immediately.
    - Else stay until btn_out==0, then go to ARM.
  - OVER: fsm_rst=1 and game_over=1; score and level are held for display. start_rise -> IDLE.
- No fsm_en pulses occur outside RUN.
- fsm_rst and fsm_en are never high in the same cycle.
- fsm_win and fsm_lose are ignored outside RUN.
- start_rise is ignored in ARM, RUN, WIN_HOLD and LOSE_HOLD.
- The score, level and lives updates happen exactly once per entry into WIN_HOLD or LOSE_HOLD, in the transition cycle out of RUN.
- Held buttons in WIN_HOLD or LOSE_HOLD stall the game indefinitely; this is the intended behaviour.

Test Plan (bench params: BASE_DIV=8, DIV_STEP=2, MAX_LEVEL=3, LIVES=2):
- Reset mid-RUN with counter=5 -> next cycle: IDLE, fsm_rst=1, score=0, level=0, lives=2, fsm_en=0.
- start pulse, no win/lose -> one ARM cycle with fsm_rst=1. Then in RUN, fsm_en pulses every 8 cycles, the first pulse 8 cycles after entering RUN.
- fsm_win while btn_out=4'b0100, buttons released 3 cycles later:
  - score=1 and level=1 on the cycle after win.
  - ARM on the cycle after btn_out==0.
  - fsm_en period is then 6.
- Four consecutive wins -> level saturates at 3 and the period is 2 (fsm_en every other cycle); score=4.
- fsm_win and fsm_lose high in the same cycle in RUN -> WIN_HOLD, lives unchanged.
- Two losses:
  - First loss: lives=1, back to ARM after release.
  - Second loss: lives=0, game_over=1, fsm_rst=1, score retained.
  - start then goes to IDLE; a second start begins a new game with score=0 and lives=2.
